// File: rtl/test_numbers_pkg.sv
// test_numbers_pkg: default 640x480 timing, colours, pixel struct and the
// 8x8 digit font shared by the VGA digit test-pattern generator.
package test_numbers_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // 10 bits hold both 0..799 and 0..524
    localparam int unsigned CNT_W = 10;

    localparam logic [11:0] FG_COLOR_DEF = 12'hFFF;
    localparam logic [11:0] BG_COLOR_DEF = 12'h008;
    localparam logic [11:0] BORDER_COLOR = 12'hF00;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Glyph rows for digits 0..9, eight rows each; bit 7 is the leftmost column
    localparam logic [7:0] FONT [80] = '{
        8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
        8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h06, 8'h0E, 8'h1E, 8'h66, 8'h7F, 8'h06, 8'h06, 8'h00,
        8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h7E, 8'h66, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00,
        8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00
    };

    // Row bits of a digit glyph; digits above 9 read as blank
    function automatic logic [7:0] glyph_row(input logic [3:0] digit, input logic [2:0] row);
        logic [7:0] bits;
        bits = '0;
        if (digit <= 4'd9) begin
            bits = FONT[{digit, row}];
        end
        return bits;
    endfunction

endpackage

// File: rtl/test_numbers_vga_if.sv
// test_numbers_vga_if: raster position bus from the timing generator to the
// pixel stage (counters plus raw, unregistered sync and visible flags).
interface test_numbers_vga_if;
    import test_numbers_pkg::*;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             visible;

    modport master (output h_cnt, output v_cnt, output hsync_raw, output vsync_raw, output visible);
    modport slave  (input  h_cnt, input  v_cnt, input  hsync_raw, input  vsync_raw, input  visible);
endinterface

// File: rtl/test_numbers_vga_timing.sv
// vga_timing: horizontal/vertical raster counters and the raw sync/visible
// flags derived from them. Sync flags are active low.
module vga_timing import test_numbers_pkg::*; #(
    parameter int unsigned H_VISIBLE = test_numbers_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = test_numbers_pkg::H_FP,
    parameter int unsigned H_SYNC    = test_numbers_pkg::H_SYNC,
    parameter int unsigned H_BP      = test_numbers_pkg::H_BP,
    parameter int unsigned V_VISIBLE = test_numbers_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = test_numbers_pkg::V_FP,
    parameter int unsigned V_SYNC    = test_numbers_pkg::V_SYNC,
    parameter int unsigned V_BP      = test_numbers_pkg::V_BP
) (
    input  logic                clk,
    input  logic                rst_n,
    test_numbers_vga_if.master  tbus
);

    localparam int unsigned H_TOT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    // Advance h every pixel; v steps when h wraps, both wrap at their totals
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == CNT_W'(H_TOT - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == CNT_W'(V_TOT - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Raw position flags for the pixel stage
    always_comb begin
        tbus.h_cnt     = h_cnt_q;
        tbus.v_cnt     = v_cnt_q;
        tbus.hsync_raw = !((h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END)));
        tbus.vsync_raw = !((v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END)));
        tbus.visible   = (h_cnt_q < CNT_W'(H_VISIBLE)) && (v_cnt_q < CNT_W'(V_VISIBLE));
    end

endmodule

// File: rtl/test_numbers_vga_top.sv
// test_numbers_vga_top: 640x480 VGA test pattern showing digits 0..9 as one
// row of scaled 8x8 glyphs over a solid background. Sync and colour are
// registered together, so both lag the raster counters by one clock.
// Optional macro TEST_NUMBERS_BORDER_EN draws a one-pixel red frame around
// the visible area, overriding glyph and background.
module test_numbers_vga_top import test_numbers_pkg::*; #(
    parameter int unsigned H_VISIBLE = test_numbers_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = test_numbers_pkg::H_FP,
    parameter int unsigned H_SYNC    = test_numbers_pkg::H_SYNC,
    parameter int unsigned H_BP      = test_numbers_pkg::H_BP,
    parameter int unsigned V_VISIBLE = test_numbers_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = test_numbers_pkg::V_FP,
    parameter int unsigned V_SYNC    = test_numbers_pkg::V_SYNC,
    parameter int unsigned V_BP      = test_numbers_pkg::V_BP,
    parameter int unsigned X0        = 0,
    parameter int unsigned Y0        = 0,
    parameter int unsigned SCALE     = 4,
    parameter logic [11:0] FG_COLOR  = FG_COLOR_DEF,
    parameter logic [11:0] BG_COLOR  = BG_COLOR_DEF
) (
    input  logic       Clock,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] VGA_R,
    output logic [3:0] VGA_G,
    output logic [3:0] VGA_B
);

    // SCALE is a power of two, so dividing by it is a right shift
    localparam int unsigned SHIFT = $clog2(SCALE);
    localparam int unsigned ROW_W = 80 * SCALE;
    localparam int unsigned ROW_H = 8 * SCALE;

    test_numbers_vga_if tbus ();

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clk   (Clock),
        .rst_n (reset),
        .tbus  (tbus)
    );

    logic [CNT_W:0]   dx, dy;
    logic [CNT_W-1:0] cell_x, cell_y;
    logic [7:0]       bits;
    logic             in_row;
    logic             pix_on;
    rgb_t             rgb_d, rgb_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;

    // Glyph lookup and colour select for the current raster position
    always_comb begin
        // one extra bit so positions left of/above the row wrap far out of range
        dx     = {1'b0, tbus.h_cnt} - (CNT_W + 1)'(X0);
        dy     = {1'b0, tbus.v_cnt} - (CNT_W + 1)'(Y0);
        in_row = (dx < (CNT_W + 1)'(ROW_W)) && (dy < (CNT_W + 1)'(ROW_H));
        cell_x = CNT_W'(dx >> SHIFT);
        cell_y = CNT_W'(dy >> SHIFT);
        bits   = glyph_row(4'(cell_x >> 3), 3'(cell_y));
        pix_on = bits[3'd7 - 3'(cell_x)];

        rgb_d = '0;
        if (tbus.visible) begin
            rgb_d = BG_COLOR;
            if (in_row && pix_on) begin
                rgb_d = FG_COLOR;
            end
`ifdef TEST_NUMBERS_BORDER_EN
            if ((tbus.h_cnt == '0) || (tbus.h_cnt == CNT_W'(H_VISIBLE - 1)) ||
                (tbus.v_cnt == '0) || (tbus.v_cnt == CNT_W'(V_VISIBLE - 1))) begin
                rgb_d = BORDER_COLOR;
            end
`endif
        end
        hsync_d = tbus.hsync_raw;
        vsync_d = tbus.vsync_raw;
    end

    // Output registers; reset holds syncs inactive and colour black
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign VGA_R = rgb_q.r;
    assign VGA_G = rgb_q.g;
    assign VGA_B = rgb_q.b;

endmodule

// File: tb/tb_test_numbers_vga_top.sv
// Scoreboard bench for test_numbers_vga_top. The vertical timing is shortened
// so that complete frames, vsync and the frame wrap fit in a short run; the
// horizontal timing and glyph geometry are the defaults.
module tb_test_numbers_vga_top;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 40;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int X0     = 0;
    localparam int Y0     = 0;
    localparam int SCALE  = 4;
    localparam logic [11:0] FG     = 12'hFFF;
    localparam logic [11:0] BG     = 12'h008;
    localparam logic [11:0] BORDER = 12'hF00;

    localparam logic [7:0] FONT_TB [10][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h06, 8'h0E, 8'h1E, 8'h66, 8'h7F, 8'h06, 8'h06, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h66, 8'h0C, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h66, 8'h3C, 8'h00}
    };

    typedef struct {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        int          h;
        int          v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync;
    logic [3:0] r, g, b;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pos = 0;

    test_numbers_vga_if ref_bus ();

    always #5 clk = ~clk;

    test_numbers_vga_top #(
        .H_VISIBLE (H_VIS),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VIS),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .X0        (X0),
        .Y0        (Y0),
        .SCALE     (SCALE),
        .FG_COLOR  (FG),
        .BG_COLOR  (BG)
    ) dut (
        .Clock (clk),
        .reset (rst_n),
        .hsync (hsync),
        .vsync (vsync),
        .VGA_R (r),
        .VGA_G (g),
        .VGA_B (b)
    );

    // Colour of a visible pixel straight from the geometry rules
    function automatic logic [11:0] ref_colour(input int x, input int y);
        int         digit, col, row;
        logic [7:0] bits;
`ifdef TEST_NUMBERS_BORDER_EN
        if (x == 0 || x == H_VIS - 1 || y == 0 || y == V_VIS - 1) return BORDER;
`endif
        if (x < X0 || x >= X0 + 80 * SCALE || y < Y0 || y >= Y0 + 8 * SCALE) return BG;
        digit = (x - X0) / (8 * SCALE);
        col   = ((x - X0) / SCALE) % 8;
        row   = (y - Y0) / SCALE;
        bits  = FONT_TB[digit][row];
        return bits[7 - col] ? FG : BG;
    endfunction

    // Model: at each edge predict what the outputs will show until the next edge
    initial begin
        exp_t e;
        int   h, v;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                pos   = 0;
                e.hs  = 1'b1;
                e.vs  = 1'b1;
                e.rgb = 12'h000;
                e.h   = -1;
                e.v   = -1;
            end else begin
                h = pos % H_TOT;
                v = (pos / H_TOT) % V_TOT;
                ref_bus.h_cnt     = 10'(h);
                ref_bus.v_cnt     = 10'(v);
                ref_bus.hsync_raw = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                ref_bus.vsync_raw = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                ref_bus.visible   = (h < H_VIS) && (v < V_VIS);
                e.hs  = ref_bus.hsync_raw;
                e.vs  = ref_bus.vsync_raw;
                e.rgb = ref_bus.visible ? ref_colour(int'(ref_bus.h_cnt), int'(ref_bus.v_cnt)) : 12'h000;
                e.h   = h;
                e.v   = v;
                pos++;
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: compare the registered outputs mid-cycle against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({hsync, vsync, r, g, b} !== {e.hs, e.vs, e.rgb}) begin
                    errors++;
                    $display("FAIL pixel h=%0d v=%0d: got hs=%b vs=%b rgb=%h%h%h, want hs=%b vs=%b rgb=%h",
                             e.h, e.v, hsync, vsync, r, g, b, e.hs, e.vs, e.rgb);
                end
            end
        end
    end

    // Asserting reset must force idle outputs at once, without a clock edge
    task automatic reset_mid_frame(input int hold);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hsync, vsync, r, g, b} !== {1'b1, 1'b1, 12'h000}) begin
            errors++;
            $display("FAIL async_reset: got hs=%b vs=%b rgb=%h%h%h, want hs=1 vs=1 rgb=000",
                     hsync, vsync, r, g, b);
        end
        repeat (hold) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b1;
        // one full frame plus the start of the next
        repeat (H_TOT * V_TOT + 2 * H_TOT) @(negedge clk);
        repeat ($urandom_range(100, 3000)) @(negedge clk);
        reset_mid_frame(int'($urandom_range(3, 20)));
        repeat (3 * H_TOT) @(negedge clk);
        repeat ($urandom_range(10, 700)) @(negedge clk);
        reset_mid_frame(int'($urandom_range(1, 5)));
        repeat (H_TOT + 50) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
